// File: rtl/multiword_add_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multiword_add_sequencer_if: control handshake and shared-adder bus   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface multiword_add_sequencer_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cy_out;
   logic         ovf;
   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_cin;
   logic [7:0]   add_sum;
   logic         add_cout;

   modport slave (
      input  start, sub, a, b, add_sum, add_cout,
      output busy, done, sum, cy_out, ovf, add_a, add_b, add_cin
   );

   modport master (
      output start, sub, a, b, add_sum, add_cout,
      input  busy, done, sum, cy_out, ovf, add_a, add_b, add_cin
   );
endinterface
`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multiword_add_sequencer: byte-serial add/sub over an external adder  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multiword_add_sequencer #(
   parameter int NBYTES = 4
) (
   input  wire                        clk,
   input  wire                        rst_n,
   multiword_add_sequencer_if.slave   bus
);
   localparam int W    = 8 * NBYTES;
   localparam int IDXW = $clog2(NBYTES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NBYTES - 1);

   logic [1:0]      state_q, state_d;
   logic [IDXW-1:0] idx_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            carry_q;
   logic [W-1:0]    sum_q;
   logic            cy_q;
   logic            ovf_q;

   logic w_accept;
   logic w_last;

   assign w_accept = (state_q == S_IDLE) && bus.start;
   assign w_last   = (state_q == S_RUN) && (idx_q == C_LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (w_last)    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy    = (state_q != S_IDLE);
      bus.done    = (state_q == S_DONE);
      bus.add_a   = 8'h00;
      bus.add_b   = 8'h00;
      bus.add_cin = 1'b0;
      if (state_q == S_RUN) begin
         bus.add_a   = a_q[{idx_q, 3'b000} +: 8];
         bus.add_b   = b_q[{idx_q, 3'b000} +: 8];
         bus.add_cin = carry_q;
      end
   end

   // Subtraction is a + ~b + 1: invert B once at capture and seed the carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cy_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (w_accept) begin
         a_q     <= bus.a;
         b_q     <= bus.sub ? ~bus.b : bus.b;
         carry_q <= bus.sub;
         idx_q   <= '0;
      end else if (state_q == S_RUN) begin
         sum_q[{idx_q, 3'b000} +: 8] <= bus.add_sum;
         carry_q <= bus.add_cout;
         if (w_last) begin
            cy_q  <= bus.add_cout;
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (bus.add_sum[7] != a_q[W-1]);
         end else begin
            idx_q <= idx_q + IDXW'(1);
         end
      end
   end

   assign bus.sum    = sum_q;
   assign bus.cy_out = cy_q;
   assign bus.ovf    = ovf_q;
endmodule
`default_nettype wire
